// File: rtl/uart_tx_bus.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, responding on the CPU bus.
// Define UART_TX_IRQ_EN to build the tx_empty_interrupt pulse logic; otherwise the port is tied low.
module uart_tx_bus #(
    parameter logic [26:0] BASE_ADDR   = 27'h0,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic        busy,
    output logic [31:0] q,
    output logic        uart_out,
    output logic        tx_empty_interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] BUS_IDLE   = 2'd0;
    localparam logic [1:0] BUS_ACCESS = 2'd1;
    localparam logic [1:0] BUS_STALL  = 2'd2;
    localparam logic [1:0] BUS_DONE   = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic [1:0]    bus_state_reg;
    logic [1:0]    reg_sel_reg;
    logic          we_reg;
    logic [15:0]   wdata_reg;
    logic [31:0]   q_reg;
    logic [15:0]   div_reg;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    rd_data_reg;

    logic [1:0]    tx_state_reg;
    logic [15:0]   baud_cnt_reg;
    logic [15:0]   div_lat_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          uart_out_reg;

    logic          hit;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic          tx_active;
    logic          tick;
    logic          pop;
    logic          space;
    logic          data_wr;
    logic          push;
    logic [15:0]   count_ext;
    logic [31:0]   rd_value;
    logic          unused_bits;

    assign hit        = (address[26:2] == BASE_ADDR[26:2]);
    assign accept     = (bus_state_reg == BUS_IDLE) && start && hit;
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign tx_active  = (tx_state_reg != TX_IDLE);
    assign tick       = (baud_cnt_reg == div_lat_reg);

    // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
    assign pop     = !fifo_empty && ((tx_state_reg == TX_IDLE) || ((tx_state_reg == TX_STOP) && tick));
    assign space   = !fifo_full || pop;
    assign data_wr = we_reg && (reg_sel_reg == 2'd0);
    assign push    = space && (((bus_state_reg == BUS_ACCESS) && data_wr) || (bus_state_reg == BUS_STALL));

    assign busy = accept || (bus_state_reg == BUS_ACCESS) || (bus_state_reg == BUS_STALL);
    assign q        = q_reg;
    assign uart_out = uart_out_reg;

    assign count_ext   = 16'(count_reg);
    assign unused_bits = ^{data[31:16], count_ext[15:8]};

    always_comb begin
        rd_value = 32'h0;
        case (reg_sel_reg)
            2'd1:    rd_value = {16'h0, count_ext[7:0], 5'b0, tx_active, fifo_empty, fifo_full};
            2'd2:    rd_value = {16'h0, div_reg};
            default: rd_value = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_state_reg <= BUS_IDLE;
            reg_sel_reg   <= 2'd0;
            we_reg        <= 1'b0;
            wdata_reg     <= 16'h0;
            q_reg         <= 32'h0;
            div_reg       <= DEFAULT_DIV;
        end else begin
            case (bus_state_reg)
                BUS_IDLE: begin
                    if (accept) begin
                        reg_sel_reg   <= address[1:0];
                        we_reg        <= we;
                        wdata_reg     <= data[15:0];
                        bus_state_reg <= BUS_ACCESS;
                    end
                end
                BUS_ACCESS: begin
                    if (!we_reg) begin
                        q_reg         <= rd_value;
                        bus_state_reg <= BUS_DONE;
                    end else begin
                        if (reg_sel_reg == 2'd2) begin
                            div_reg <= wdata_reg;
                        end
                        bus_state_reg <= (data_wr && !space) ? BUS_STALL : BUS_DONE;
                    end
                end
                BUS_STALL: begin
                    if (space) begin
                        bus_state_reg <= BUS_DONE;
                    end
                end
                default: bus_state_reg <= BUS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage kept free of reset so it maps onto block RAM; the popped byte is ready one clock later.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= wdata_reg[7:0];
        end
        if (pop) begin
            rd_data_reg <= fifo_mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            baud_cnt_reg <= 16'h0;
            div_lat_reg  <= 16'h0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'h0;
            uart_out_reg <= 1'b1;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_state_reg <= TX_START;
                        div_lat_reg  <= div_reg;
                        baud_cnt_reg <= 16'h0;
                        uart_out_reg <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        baud_cnt_reg <= 16'h0;
                        shift_reg    <= rd_data_reg;
                        uart_out_reg <= rd_data_reg[0];
                        bit_idx_reg  <= 3'd0;
                        tx_state_reg <= TX_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        baud_cnt_reg <= 16'h0;
                        if (bit_idx_reg == 3'd7) begin
                            tx_state_reg <= TX_STOP;
                            uart_out_reg <= 1'b1;
                        end else begin
                            bit_idx_reg  <= bit_idx_reg + 1'b1;
                            shift_reg    <= {1'b0, shift_reg[7:1]};
                            uart_out_reg <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (tick) begin
                        baud_cnt_reg <= 16'h0;
                        if (!fifo_empty) begin
                            tx_state_reg <= TX_START;
                            div_lat_reg  <= div_reg;
                            uart_out_reg <= 1'b0;
                        end else begin
                            tx_state_reg <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (tx_state_reg == TX_STOP) && tick && fifo_empty;
        end
    end

    assign tx_empty_interrupt = irq_reg;
`else
    assign tx_empty_interrupt = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_bus.sv
// Directed bench for uart_tx_bus: register access, 8N1 framing, FIFO stall, decode and reset abort.
module tb_uart_tx_bus;
    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] address;
    logic [31:0] data;
    logic        we;
    logic        start;
    logic        busy;
    logic [31:0] q;
    logic        uart_out;
    logic        tx_empty_interrupt;

`ifdef UART_TX_IRQ_EN
    localparam int IRQ_EXP = 1;
`else
    localparam int IRQ_EXP = 0;
`endif

    uart_tx_bus dut (
        .clk                (clk),
        .reset              (reset),
        .address            (address),
        .data               (data),
        .we                 (we),
        .start              (start),
        .busy               (busy),
        .q                  (q),
        .uart_out           (uart_out),
        .tx_empty_interrupt (tx_empty_interrupt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic line_log[$];
    int   cyc_log[$];
    bit   log_en = 1'b0;
    int   irq_cnt = 0;

    always @(negedge clk) begin
        if (log_en) begin
            line_log.push_back(uart_out);
            cyc_log.push_back(cyc);
        end
        if (tx_empty_interrupt === 1'b1) irq_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int last_start_cyc;
    int last_done_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_op(input logic [26:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] r, output int nb);
        nb = 0;
        @(posedge clk); #1;
        address = a; data = d; we = w; start = 1'b1;
        last_start_cyc = cyc;
        #1;
        if (busy) nb++;
        @(posedge clk); #1;
        start = 1'b0; we = 1'b0;
        for (int i = 0; i < 2000 && busy; i++) begin
            nb++;
            @(posedge clk); #1;
        end
        if (busy) chk("busy_timeout", {31'b0, busy}, 32'h0);
        last_done_cyc = cyc;
        r = q;
        $display("bus addr=0x%07h we=%0b data=0x%08h q=0x%08h busy_cycles=%0d", a, w, d, r, nb);
        @(posedge clk);
    endtask

    task automatic clear_log();
        log_en = 1'b0;
        line_log.delete();
        cyc_log.delete();
        log_en = 1'b1;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 5000 && line_log.size() < n; i++) @(posedge clk);
        if (line_log.size() < n) chk("log_timeout", line_log.size(), n);
    endtask

    function automatic int find_fall(input int from);
        for (int i = from; i < line_log.size(); i++)
            if (line_log[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic logic [9:0] sample_frame(input int s, input int bl);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[i] = line_log[s + bl * i + bl / 2];
        return w;
    endfunction

    logic [31:0] r;
    int          nb;
    int          f;
    int          errs;
    logic [9:0]  a5_bits;
    logic [7:0]  kb;
    logic        expbit;
    logic [3:0]  got4;

    initial begin
        reset = 1'b1; address = '0; data = '0; we = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_q", q, 32'h0);
        chk("rst_uart_out", {31'b0, uart_out}, 32'h1);
        chk("rst_irq", {31'b0, tx_empty_interrupt}, 32'h0);
        reset = 1'b0;

        // Register reads after reset.
        bus_op(27'h1, 1'b0, 32'h0, r, nb);
        chk("status_reset", r, 32'h2);
        chk("status_busy_cycles", nb, 2);
        bus_op(27'h2, 1'b0, 32'h0, r, nb);
        chk("div_reset", r, 32'd433);
        chk("div_busy_cycles", nb, 2);

        // Out-of-range address: ignored completely.
        clear_log();
        bus_op(27'h4, 1'b0, 32'h0, r, nb);
        chk("bad_rd_busy", nb, 0);
        chk("bad_rd_q_held", r, 32'd433);
        bus_op(27'h4, 1'b1, 32'h55, r, nb);
        chk("bad_wr_busy", nb, 0);
        repeat (20) @(posedge clk);
        errs = 0;
        foreach (line_log[i]) if (line_log[i] !== 1'b1) errs++;
        chk("bad_wr_line_idle", errs, 0);
        bus_op(27'h1, 1'b0, 32'h0, r, nb);
        chk("bad_wr_status", r, 32'h2);

        // DIV masking and reserved register.
        bus_op(27'h2, 1'b1, 32'hFFFF1234, r, nb);
        bus_op(27'h2, 1'b0, 32'h0, r, nb);
        chk("div_readback", r, 32'h00001234);
        bus_op(27'h3, 1'b1, 32'hDEADBEEF, r, nb);
        bus_op(27'h3, 1'b0, 32'h0, r, nb);
        chk("reserved_read", r, 32'h0);
        bus_op(27'h2, 1'b0, 32'h0, r, nb);
        chk("div_after_reserved", r, 32'h00001234);

        // Single 0xA5 frame at DIV=3.
        bus_op(27'h2, 1'b1, 32'd3, r, nb);
        clear_log();
        irq_cnt = 0;
        bus_op(27'h0, 1'b1, 32'hA5, r, nb);
        chk("a5_busy_cycles", nb, 2);
        repeat (70) @(posedge clk);
        f = find_fall(0);
        chk("a5_fall_found", {31'b0, f >= 0}, 32'h1);
        if (f >= 0) begin
            wait_log(f + 50);
            chk("a5_latency", cyc_log[f] - last_start_cyc, 3);
            a5_bits = 10'b11_0100_1010;
            for (int k = 0; k < 10; k++) begin
                got4 = {line_log[f + 4*k], line_log[f + 4*k + 1], line_log[f + 4*k + 2], line_log[f + 4*k + 3]};
                chk($sformatf("a5_bit%0d", k), {28'b0, got4}, {28'b0, {4{a5_bits[k]}}});
            end
            errs = 0;
            for (int i = f + 40; i < f + 50; i++) if (line_log[i] !== 1'b1) errs++;
            chk("a5_idle_after", errs, 0);
        end
        chk("a5_irq_pulses", irq_cnt, IRQ_EXP);

        // Fill the FIFO behind a long frame, then stall one more write.
        bus_op(27'h2, 1'b1, 32'd15, r, nb);
        clear_log();
        irq_cnt = 0;
        bus_op(27'h0, 1'b1, 32'h00, r, nb);
        bus_op(27'h2, 1'b1, 32'd1, r, nb);
        for (int k = 1; k <= 16; k++) bus_op(27'h0, 1'b1, k, r, nb);
        bus_op(27'h1, 1'b0, 32'h0, r, nb);
        chk("status_full", r, 32'h00001005);
        bus_op(27'h0, 1'b1, 32'h11, r, nb);
        chk("stall_busy_long", {31'b0, nb > 2}, 32'h1);
        f = find_fall(0);
        chk("fill_fall_found", {31'b0, f >= 0}, 32'h1);
        if (f >= 0) begin
            wait_log(f + 530);
            chk("stall_release_cycle", last_done_cyc - cyc_log[f], 160);
            chk("frame0", {22'b0, sample_frame(f, 16)}, 32'h200);
            errs = 0;
            for (int k = 1; k <= 17; k++) begin
                kb = k[7:0];
                chk($sformatf("frame%0d", k), {22'b0, sample_frame(f + 160 + 20*(k-1), 2)},
                    {22'b0, 1'b1, kb, 1'b0});
                for (int b = 0; b < 10; b++) begin
                    expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : kb[b-1];
                    for (int j = 0; j < 2; j++)
                        if (line_log[f + 160 + 20*(k-1) + 2*b + j] !== expbit) errs++;
                end
            end
            for (int i = f + 500; i < f + 530; i++) if (line_log[i] !== 1'b1) errs++;
            chk("b2b_exact_errs", errs, 0);
        end
        chk("fill_irq_pulses", irq_cnt, IRQ_EXP);
        bus_op(27'h1, 1'b0, 32'h0, r, nb);
        chk("status_drained", r, 32'h2);

        // Reset during data bits with bytes still queued.
        bus_op(27'h2, 1'b1, 32'd3, r, nb);
        clear_log();
        irq_cnt = 0;
        for (int k = 0; k < 3; k++) bus_op(27'h0, 1'b1, 32'h00, r, nb);
        bus_op(27'h1, 1'b0, 32'h0, r, nb);
        chk("status_queued", r, 32'h00000204);
        f = find_fall(0);
        chk("rst_fall_found", {31'b0, f >= 0}, 32'h1);
        if (f >= 0) begin
            for (int i = 0; i < 200 && cyc < cyc_log[f] + 18; i++) begin
                @(posedge clk); #1;
            end
        end
        chk("pre_reset_line", {31'b0, uart_out}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_abort_line", {31'b0, uart_out}, 32'h1);
        reset = 1'b0;
        bus_op(27'h1, 1'b0, 32'h0, r, nb);
        chk("status_after_reset", r, 32'h2);
        clear_log();
        repeat (150) @(posedge clk);
        errs = 0;
        foreach (line_log[i]) if (line_log[i] !== 1'b1) errs++;
        chk("after_reset_silent", errs, 0);
        chk("after_reset_irq", irq_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
